// File: rtl/pbit_sched_pkg.sv
// Shared definitions for the p-bit group update sequencer: group geometry,
// FSM state encoding and the last-group test.
package pbit_sched_pkg;

    localparam int NUM_GROUPS = 5;
    localparam int GROUP_W    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRE   = 2'd1,
        SETTLE = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    function automatic logic last_group(input logic [GROUP_W-1:0] g);
        return g == GROUP_W'(NUM_GROUPS - 1);
    endfunction

endpackage

// File: rtl/group_slot_timer.sv
// Loadable settle-window down-counter; expire is high in the cycle the count
// reads 1, which is the last cycle of a slot.
module group_slot_timer #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              dec,
    output logic              expire
);

    logic [HOLD_W-1:0] cnt_d, cnt_q;

    // NOTE: give every combinational output a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == HOLD_W'(1));

endmodule

// File: rtl/group_update_sequencer.sv
// Steps the colour-group select through 0..NUM_GROUPS-1, strobing update_en once
// per slot and holding the group through a settle window; counts sweeps.
module group_update_sequencer
    import pbit_sched_pkg::*;
#(
    parameter int HOLD_W  = 8,
    parameter int SWEEP_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic [HOLD_W-1:0]  hold_cycles,
    output logic [0:GROUP_W-1] group_EN,
    output logic               update_en,
    output logic               sweep_tick,
    output logic [SWEEP_W-1:0] sweep_count,
    output logic               busy,
    output logic               done
);

    seq_state_t         state_d, state_q;
    logic [GROUP_W-1:0] g_d, g_q;
    logic [SWEEP_W-1:0] cnt_d, cnt_q;
    logic [SWEEP_W-1:0] target_d, target_q;
    logic [HOLD_W-1:0]  hold_d, hold_q;
    logic               pend_d, pend_q;
    logic               advance, tick, tmr_load, tmr_expire, stop_seen;

    group_slot_timer #(.HOLD_W(HOLD_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (hold_q),
        .dec      (state_q == SETTLE),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        hold_d   = hold_q;
        tmr_load = 1'b0;
        tick     = 1'b0;
        advance  = 1'b0;
        stop_seen = pend_q | stop;

        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = num_sweeps;
                    hold_d   = hold_cycles;
                    cnt_d    = '0;
                    g_d      = '0;
                    state_d  = FIRE;
                end
            end
            FIRE: begin
                if (hold_q == '0) begin
                    advance = 1'b1;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE:  advance = tmr_expire;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Slot boundary: the sweep is counted before a pending stop is honoured.
        if (advance) begin
            if (!last_group(g_q)) begin
                if (stop_seen) begin
                    state_d = IDLE;
                end else begin
                    g_d     = g_q + GROUP_W'(1);
                    state_d = FIRE;
                end
            end else begin
                tick  = 1'b1;
                cnt_d = cnt_q + SWEEP_W'(1);
                if ((target_q != '0) && (cnt_d == target_q)) begin
                    state_d = FINISH;
                end else if (stop_seen) begin
                    state_d = IDLE;
                end else begin
                    g_d     = '0;
                    state_d = FIRE;
                end
            end
        end

        pend_d = (state_d != IDLE) && (state_q != IDLE) && stop_seen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            g_q      <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            hold_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            hold_q   <= hold_d;
            pend_q   <= pend_d;
        end
    end

    assign group_EN    = g_q;
    assign update_en   = (state_q == FIRE);
    assign sweep_tick  = tick;
    assign sweep_count = cnt_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FINISH);

endmodule

// File: tb/tb_group_update_sequencer.sv
// Directed bench for group_update_sequencer: a per-cycle vector table for the
// free-run/start/stop basics, then hand sequences for settle, stop and reset cases.
module tb_group_update_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [31:0] num_sweeps;
    logic [7:0]  hold_cycles;
    logic [0:2]  group_EN;
    logic        update_en;
    logic        sweep_tick;
    logic [31:0] sweep_count;
    logic        busy;
    logic        done;

    int n_vec  = 0;
    int n_fail = 0;

    group_update_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .num_sweeps  (num_sweeps),
        .hold_cycles (hold_cycles),
        .group_EN    (group_EN),
        .update_en   (update_en),
        .sweep_tick  (sweep_tick),
        .sweep_count (sweep_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic [31:0] num;
        logic [7:0]  hold;
        logic [2:0]  e_g;
        logic        e_upd;
        logic        e_tick;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] g, input logic upd,
                             input logic tick, input logic bsy, input logic dn,
                             input logic [31:0] cnt);
        check({tag, ".group_EN"},    32'(group_EN),   32'(g));
        check({tag, ".update_en"},   32'(update_en),  32'(upd));
        check({tag, ".sweep_tick"},  32'(sweep_tick), 32'(tick));
        check({tag, ".busy"},        32'(busy),       32'(bsy));
        check({tag, ".done"},        32'(done),       32'(dn));
        check({tag, ".sweep_count"}, sweep_count,     cnt);
    endtask

    function automatic vec_t mk(input logic st, input logic sp, input logic [31:0] num,
                                input logic [7:0] hold, input logic [2:0] g, input logic upd,
                                input logic tick, input logic bsy, input logic dn,
                                input logic [31:0] cnt);
        vec_t v;
        v.start = st; v.stop = sp; v.num = num; v.hold = hold;
        v.e_g = g; v.e_upd = upd; v.e_tick = tick; v.e_busy = bsy; v.e_done = dn; v.e_cnt = cnt;
        return v;
    endfunction

    // Issue start at the next negedge; the following negedge is cycle k=0 (first strobe).
    task automatic kick(input logic [31:0] num, input logic [7:0] hold);
        @(negedge clk);
        start = 1'b1; num_sweeps = num; hold_cycles = hold;
    endtask

    initial begin
        // Expected outputs are checked first, then the row's inputs are driven for the next edge.
        //             st sp num hold  g upd tk bsy dn cnt
        vecs[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // idle after reset; start free-run, hold 0
        vecs[1]  = mk(0, 0, 0, 0,  0, 1, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0,  1, 1, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0,  2, 1, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,  3, 1, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0,  4, 1, 1, 1, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0,  0, 1, 0, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0,  1, 1, 0, 1, 0, 1);
        vecs[8]  = mk(1, 0, 7, 9,  2, 1, 0, 1, 0, 1);  // start while busy, new inputs: ignored
        vecs[9]  = mk(0, 0, 7, 9,  3, 1, 0, 1, 0, 1);
        vecs[10] = mk(0, 0, 7, 9,  4, 1, 1, 1, 0, 1);
        vecs[11] = mk(0, 0, 7, 9,  0, 1, 0, 1, 0, 2);
        vecs[12] = mk(0, 0, 7, 9,  1, 1, 0, 1, 0, 2);
        vecs[13] = mk(0, 0, 7, 9,  2, 1, 0, 1, 0, 2);
        vecs[14] = mk(0, 0, 7, 9,  3, 1, 0, 1, 0, 2);
        vecs[15] = mk(0, 0, 7, 9,  4, 1, 1, 1, 0, 2);
        vecs[16] = mk(0, 1, 7, 9,  0, 1, 0, 1, 0, 3);  // 15 strobes done; stop ends group-0 slot
        vecs[17] = mk(0, 1, 7, 9,  0, 0, 0, 0, 0, 3);  // idle, no done; stop in idle ignored
        vecs[18] = mk(1, 1, 1, 0,  0, 0, 0, 0, 0, 3);  // start+stop together: start wins
        vecs[19] = mk(0, 0, 1, 0,  0, 1, 0, 1, 0, 0);
        vecs[20] = mk(0, 0, 1, 0,  1, 1, 0, 1, 0, 0);
        vecs[21] = mk(0, 0, 1, 0,  2, 1, 0, 1, 0, 0);
        vecs[22] = mk(0, 0, 1, 0,  3, 1, 0, 1, 0, 0);
        vecs[23] = mk(0, 0, 1, 0,  4, 1, 1, 1, 0, 0);
        vecs[24] = mk(0, 0, 1, 0,  4, 0, 0, 1, 1, 1);  // FINISH: done pulse
        vecs[25] = mk(0, 0, 1, 0,  4, 0, 0, 0, 0, 1);

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; num_sweeps = '0; hold_cycles = '0;
        #1;
        check_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].e_g, vecs[i].e_upd, vecs[i].e_tick,
                      vecs[i].e_busy, vecs[i].e_done, vecs[i].e_cnt);
            start = vecs[i].start; stop = vecs[i].stop;
            num_sweeps = vecs[i].num; hold_cycles = vecs[i].hold;
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0;

        // Bounded run: hold 3, two sweeps -> 10 slots of 4 cycles, done at k=40.
        kick(32'd2, 8'd3);
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k < 40)
                check_all($sformatf("bound.k%0d", k), 3'((k / 4) % 5), (k % 4) == 0,
                          (k % 4 == 3) && ((k / 4) % 5 == 4), 1'b1, 1'b0, 32'(k / 20));
            else if (k == 40)
                check_all("bound.finish", 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 32'd2);
            else
                check_all("bound.after", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2);
        end

        // Mid-slot stop: hold 5 (6-cycle slots), stop 2 cycles into group 2's slot.
        kick(32'd0, 8'd5);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (k < 18)
                check_all($sformatf("midstop.k%0d", k), 3'(k / 6), (k % 6) == 0, 1'b0,
                          1'b1, 1'b0, 32'd0);
            else
                check_all($sformatf("midstop.idle%0d", k), 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            if (k == 14) stop = 1'b1;
        end

        // Stop during group 4's settle: sweep still counted, then idle without done.
        kick(32'd0, 8'd2);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (k < 15)
                check_all($sformatf("laststop.k%0d", k), 3'(k / 3), (k % 3) == 0, k == 14,
                          1'b1, 1'b0, 32'd0);
            else
                check_all($sformatf("laststop.idle%0d", k), 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);
            if (k == 13) stop = 1'b1;
        end

        // Async reset mid-settle (group 1, one sweep counted), then restart from group 0.
        kick(32'd0, 8'd1);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            check_all($sformatf("prerst.k%0d", k), 3'((k / 2) % 5), (k % 2) == 0, k == 9,
                      1'b1, 1'b0, 32'(k / 10));
        end
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        kick(32'd0, 8'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            check_all($sformatf("postrst.k%0d", k), 3'(k / 2), (k % 2) == 0, 1'b0,
                      1'b1, 1'b0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
